// File: rtl/uart_mmio_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_mmio_pkg                                                         |
// | Register offsets, STATUS layout and FSM encodings for uart_mmio.      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package uart_mmio_pkg;

    // Register index, taken from addr[3:2]
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // STATUS[6:0], MSB first so the packed struct maps straight onto the register
    typedef struct packed {
        logic frame_err;
        logic tx_overflow;
        logic tx_busy;
        logic rx_overrun;
        logic rx_valid;
        logic tx_empty;
        logic tx_full;
    } status_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_mmio_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_mmio_if                                                          |
// | Core data-bus window of the UART: select, strobes, data and irq.      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface uart_mmio_if;
    logic        sel;
    logic [3:0]  addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (
        output sel, addr, mem_read, mem_write, wdata,
        input  rdata, irq
    );

    modport slave (
        input  sel, addr, mem_read, mem_write, wdata,
        output rdata, irq
    );
endinterface
`default_nettype wire

// File: rtl/uart_mmio_sync_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sync_fifo                                                             |
// | Single-clock show-ahead FIFO; DEPTH must be a power of two >= 2.      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule
`default_nettype wire

// File: rtl/uart_mmio.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_mmio                                                             |
// | Memory-mapped UART: TX FIFO + serialiser, RX deserialiser, irq.       |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module uart_mmio
    import uart_mmio_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic           clk,
    input  logic           rst,
    uart_mmio_if.slave     bus,
    output logic           tx,
    input  logic           rx
);
    localparam int CPB       = CLK_FREQ / BAUD;
    localparam int HALF      = CPB / 2;
    localparam int STOP_CLKS = STOP_BITS * CPB;
    localparam int CNT_W     = $clog2(STOP_CLKS);

    localparam logic [CNT_W-1:0] CPB_LAST  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // ---------------- bus decode ----------------
    logic [1:0] reg_sel;
    logic       rd_en;
    logic       wr_en;
    logic       tx_push;
    logic       tx_drop;
    logic       rx_pop;
    logic       status_rd;
    logic       unused_bits;

    assign reg_sel     = bus.addr[3:2];
    assign rd_en       = bus.sel && bus.mem_read;
    assign wr_en       = bus.sel && bus.mem_write;
    assign rx_pop      = rd_en && (reg_sel == REG_RXDATA);
    assign status_rd   = rd_en && (reg_sel == REG_STATUS);
    assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:8]};

    // ---------------- TX FIFO ----------------
    logic [7:0] fifo_dout;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    tx_state_t  tx_state;

    assign tx_push  = wr_en && (reg_sel == REG_TXDATA) && !fifo_full;
    assign tx_drop  = wr_en && (reg_sel == REG_TXDATA) && fifo_full;
    assign fifo_pop = (tx_state == TX_IDLE) && !fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (fifo_pop),
        .din   (bus.wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ---------------- TX FSM ----------------
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx       <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx <= 1'b1;
                    if (!fifo_empty) begin
                        tx_shift <= fifo_dout;
                        tx       <= 1'b0;
                        tx_cnt   <= '0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == CPB_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx       <= tx_shift[0];
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == CPB_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx       <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx       <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == STOP_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // ---------------- RX synchroniser ----------------
    logic rx_meta;
    logic rx_sync;
    logic rx_prev;
    logic rx_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall = rx_prev && !rx_sync;

    // ---------------- RX FSM ----------------
    rx_state_t        rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_done;
    logic             rx_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_done  <= 1'b0;
            rx_bad   <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            rx_bad  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        // Line back high at mid start bit means the edge was noise
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == CPB_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == CPB_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        rx_done  <= rx_sync;
                        rx_bad   <= !rx_sync;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ---------------- RX holding register and sticky flags ----------------
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_overrun;
    logic       tx_overflow;
    logic       frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_byte     <= '0;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_overflow <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            // A read on the delivery edge frees the slot, so the new byte is accepted
            if (rx_done && (!rx_valid || rx_pop)) begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (rx_pop) begin
                rx_valid <= 1'b0;
            end

            if (rx_done && rx_valid && !rx_pop) rx_overrun <= 1'b1;
            else if (status_rd)                 rx_overrun <= 1'b0;

            if (tx_drop)        tx_overflow <= 1'b1;
            else if (status_rd) tx_overflow <= 1'b0;

            if (rx_bad)         frame_err <= 1'b1;
            else if (status_rd) frame_err <= 1'b0;
        end
    end

    // ---------------- read mux and irq ----------------
    status_t status;

    always_comb begin
        status             = '0;
        status.tx_full     = fifo_full;
        status.tx_empty    = fifo_empty;
        status.rx_valid    = rx_valid;
        status.rx_overrun  = rx_overrun;
        status.tx_busy     = (tx_state != TX_IDLE);
        status.tx_overflow = tx_overflow;
        status.frame_err   = frame_err;
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.sel) begin
            case (reg_sel)
                REG_RXDATA: bus.rdata = {24'b0, rx_byte};
                REG_STATUS: bus.rdata = {25'b0, status};
                default:    bus.rdata = '0;
            endcase
        end
    end

    assign bus.irq = rx_valid || rx_overrun || frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_mmio.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_uart_mmio                                                          |
// | Randomised scoreboard bench: bus reads and tx frames vs. a UART model.|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_uart_mmio;
    localparam int CPB   = 10;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic tx;

    uart_mmio_if bus ();

    uart_mmio #(
        .CLK_FREQ   (1_000_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (DEPTH),
        .STOP_BITS  (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave),
        .tx  (tx),
        .rx  (rx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [7:0] tx_q[$];

    // Reference model of the programmer-visible state
    bit         m_valid, m_ovr, m_ovf, m_ferr;
    logic [7:0] m_byte;
    int         lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_status();
        return {25'b0, m_ferr, m_ovf, 1'b0, m_ovr, m_valid, 1'b1, 1'b0};
    endfunction

    task automatic model_rx(input logic [7:0] b, input bit stop_ok, input bit read_on_edge);
        if (!stop_ok)                         m_ferr = 1'b1;
        else if (!m_valid || read_on_edge) begin
            m_byte  = b;
            m_valid = 1'b1;
        end else                              m_ovr  = 1'b1;
    endtask

    task automatic bus_write(input logic [3:0] off, input logic [7:0] d, input logic s = 1'b1);
        bus.sel       = s;
        bus.addr      = off | 4'($urandom_range(0, 3));
        bus.mem_write = 1'b1;
        bus.wdata     = {24'($urandom), d};
        tick(1);
        bus.sel       = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] off, input logic [31:0] exp, input string name);
        rd_q.push_back('{exp: exp, name: name});
        bus.sel      = 1'b1;
        bus.addr     = off | 4'($urandom_range(0, 3));
        bus.mem_read = 1'b1;
        tick(1);
        bus.sel      = 1'b0;
        bus.mem_read = 1'b0;
    endtask

    task automatic read_status(input string name);
        bus_read(4'h8, exp_status(), name);
        m_ovr  = 1'b0;
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic read_rxdata(input string name);
        bus_read(4'h4, {24'b0, m_byte}, name);
        m_valid = 1'b0;
    endtask

    task automatic check_irq(input string name);
        check(name, 32'(bus.irq), 32'(m_valid | m_ovr | m_ferr));
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
        rx = 1'b1;
    endtask

    task automatic wait_tx_idle();
        bit done = 1'b0;
        bus.sel  = 1'b1;
        bus.addr = 4'h8;
        for (int i = 0; i < 3000 && !done; i++) begin
            tick(1);
            if (bus.rdata[1] && !bus.rdata[4]) done = 1'b1;
        end
        bus.sel = 1'b0;
        check("tx_idle_within_budget", 32'(done), 32'd1);
        tick(2);
        check("tx_frames_outstanding", tx_q.size(), 32'd0);
    endtask

    // Bus-read monitor: every selected load is matched against the scoreboard
    initial begin : rd_monitor
        rd_exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.sel && bus.mem_read) begin
                check("read_expected", 32'(rd_q.size() != 0), 32'd1);
                if (rd_q.size() != 0) begin
                    e = rd_q.pop_front();
                    check(e.name, bus.rdata, e.exp);
                end
            end
        end
    end

    // Serial-line monitor: decodes tx frames bit by bit and checks every sample
    initial begin : tx_monitor
        bit         active = 1'b0;
        bit         ok     = 1'b1;
        int         n      = 0;
        int         bi, ph;
        logic [7:0] got    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
            end else begin
                if (!active && tx === 1'b0) begin
                    active = 1'b1;
                    n      = 0;
                    ok     = 1'b1;
                    got    = '0;
                end
                if (active) begin
                    bi = n / CPB;
                    ph = n % CPB;
                    if (bi == 0) begin
                        if (tx !== 1'b0) ok = 1'b0;
                    end else if (bi <= 8) begin
                        if (ph == 0)                 got[bi-1] = tx;
                        else if (tx !== got[bi-1])   ok = 1'b0;
                    end else if (tx !== 1'b1) begin
                        ok = 1'b0;
                    end
                    n++;
                    if (n == 10 * CPB) begin
                        active = 1'b0;
                        check("tx_frame_shape", 32'(ok), 32'd1);
                        if (ok) begin
                            check("tx_frame_expected", 32'(tx_q.size() != 0), 32'd1);
                            if (tx_q.size() != 0) check("tx_byte", got, tx_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [7:0] b;
        int         n;
        bit         ok_stop;

        bus.sel = 1'b0; bus.addr = '0; bus.mem_read = 1'b0;
        bus.mem_write = 1'b0; bus.wdata = '0;
        m_valid = 0; m_ovr = 0; m_ovf = 0; m_ferr = 0; m_byte = '0;
        tick(3);
        rst = 1'b0;
        tick(1);

        // Reset state, unmapped/ignored accesses
        check("reset_tx", 32'(tx), 32'd1);
        check_irq("reset_irq");
        read_status("reset_status");
        bus_read(4'h0, 32'd0, "txdata_reads_zero");
        bus_read(4'hC, 32'd0, "reserved_reads_zero");
        bus_write(4'h8, 8'hFF);
        bus_write(4'hC, 8'hFF);
        bus.addr = 4'h8; bus.mem_read = 1'b1;
        #1 check("rdata_unselected", bus.rdata, 32'd0);
        tick(1);
        bus.mem_read = 1'b0;
        read_status("status_after_ignored_writes");

        // Single byte
        tx_q.push_back(8'h55);
        bus_write(4'h0, 8'h55);
        wait_tx_idle();
        read_status("status_after_0x55");

        // Back-to-back bursts: one byte leaves at once, DEPTH more fit, the rest drop
        for (int k = 0; k < 4; k++) begin
            n = (k == 0) ? 6 : $urandom_range(1, 7);
            bus_write(4'h0, 8'($urandom), 1'b0);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                bus_write(4'h0, b);
                if (i < DEPTH + 1) tx_q.push_back(b);
                else               m_ovf = 1'b1;
            end
            wait_tx_idle();
            read_status("status_after_burst");
            read_status("status_overflow_cleared");
        end

        // RX 0xA3 while polling STATUS to learn the delivery edge
        lat = -1;
        fork
            rx_frame(8'hA3, 1'b1);
            begin
                bus.sel  = 1'b1;
                bus.addr = 4'h8;
                for (int i = 1; i <= 130; i++) begin
                    tick(1);
                    if (bus.rdata[2] && lat < 0) lat = i;
                end
                bus.sel = 1'b0;
            end
        join
        check("rx_delivery_latency_in_stop_bit", 32'(lat >= 94 && lat <= 101), 32'd1);
        if (lat < 2) lat = 99;
        model_rx(8'hA3, 1'b1, 1'b0);
        check_irq("irq_rx_valid");
        read_rxdata("rxdata_A3");
        check_irq("irq_after_rxdata_read");
        read_status("status_after_A3");

        // Random RX frames, some with a bad stop bit; sel=0 reads must not pop
        for (int k = 0; k < 4; k++) begin
            b       = 8'($urandom);
            ok_stop = ($urandom_range(0, 3) != 0);
            rx_frame(b, ok_stop);
            tick(10);
            model_rx(b, ok_stop, 1'b0);
            bus.addr = 4'h4; bus.mem_read = 1'b1;
            tick(1);
            bus.mem_read = 1'b0;
            check_irq("irq_random_rx");
            if (m_valid) read_rxdata("rxdata_random");
            read_status("status_random_rx");
        end

        // Overrun: two bytes without a read
        rx_frame(8'h11, 1'b1);
        model_rx(8'h11, 1'b1, 1'b0);
        rx_frame(8'h22, 1'b1);
        model_rx(8'h22, 1'b1, 1'b0);
        tick(10);
        check_irq("irq_overrun");
        read_rxdata("rxdata_keeps_first");
        read_status("status_overrun");
        check_irq("irq_after_overrun_clear");

        // RXDATA read landing on the delivery edge avoids the overrun
        rx_frame(8'h11, 1'b1);
        tick(5);
        model_rx(8'h11, 1'b1, 1'b0);
        fork
            rx_frame(8'h22, 1'b1);
            begin
                tick(lat - 1);
                bus_read(4'h4, {24'b0, m_byte}, "rxdata_on_delivery_edge");
            end
        join
        model_rx(8'h22, 1'b1, 1'b1);
        tick(10);
        read_status("status_no_overrun");
        read_rxdata("rxdata_22");
        check_irq("irq_after_edge_read");

        // Framing error, then a short glitch that must be ignored
        rx_frame(8'($urandom), 1'b0);
        tick(10);
        model_rx(8'h00, 1'b0, 1'b0);
        check_irq("irq_frame_err");
        read_status("status_frame_err");
        check_irq("irq_after_frame_err_clear");
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(120);
        read_status("status_after_glitch");
        check_irq("irq_after_glitch");

        // Reset mid-frame on both directions
        bus_write(4'h0, 8'h00);
        fork
            rx_frame(8'hFF, 1'b1);
            begin
                tick(35);
                check("tx_low_mid_frame", 32'(tx), 32'd0);
                rst = 1'b1;
                tick(1);
                check("tx_high_after_reset", 32'(tx), 32'd1);
                rst = 1'b0;
            end
        join
        tx_q.delete();
        m_valid = 0; m_ovr = 0; m_ovf = 0; m_ferr = 0;
        tick(150);
        read_status("status_after_mid_frame_reset");
        check_irq("irq_after_mid_frame_reset");
        check("tx_idle_after_reset", 32'(tx), 32'd1);

        tick(5);
        check("reads_outstanding", rd_q.size(), 32'd0);
        check("tx_frames_left", tx_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
